// File: rtl/game_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module : game_event_gen_if
// Desc   : Event/position bundle between the event generator and the
//          dinosaur-game processor wrapper.
// Rev    : 1.0 - initial release
// ============================================================================
interface game_event_gen_if;
    logic        button_signal;
    logic        screen_signal;
    logic        collision_signal;
    logic        pause_signal;
    logic [31:0] dino_y;
    logic [31:0] obstacle_x;

    modport master (
        output button_signal,
        output screen_signal,
        output collision_signal,
        output pause_signal,
        input  dino_y,
        input  obstacle_x
    );

    modport slave (
        input  button_signal,
        input  screen_signal,
        input  collision_signal,
        input  pause_signal,
        output dino_y,
        output obstacle_x
    );
endinterface
`default_nettype wire

// File: rtl/game_event_gen.sv
`default_nettype none
// ============================================================================
// Module : game_event_gen
// Desc   : Button sync/debounce, frame tick, frame-aligned jump/pause and
//          sticky collision flags for the dinosaur-game wrapper.
// Rev    : 1.0 - initial release
// ============================================================================
module game_event_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FRAME_CYCLES    = 833333,
    parameter int DINO_X          = 64,
    parameter int HIT_W           = 24,
    parameter int HIT_H           = 32
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         btn_jump_raw,
    input  wire logic         btn_pause_raw,
    game_event_gen_if.master  ev
);

    localparam int c_dcw = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_fcw = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [c_dcw-1:0]  c_deb_last   = c_dcw'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_fcw-1:0]  c_frame_last = c_fcw'(FRAME_CYCLES - 1);
    localparam logic signed [32:0] c_dino_x    = 33'(DINO_X);
    localparam logic signed [32:0] c_hit_w     = 33'(HIT_W);
    localparam logic signed [31:0] c_hit_h     = 32'(HIT_H);

    // Bit 0 = jump, bit 1 = pause
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       w_stable;
    logic [1:0]       r_stable_d;
    logic [1:0]       w_press;
    logic [c_fcw-1:0] r_frame;
    logic             w_frame_edge;
    logic             r_screen;
    logic             r_button;
    logic             r_collision;
    logic             r_pause;
    logic             r_jump_pending;
    logic signed [32:0] w_dx;
    logic             w_hit;

    assign w_raw = {btn_pause_raw, btn_jump_raw};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 2'b00;
            r_sync2    <= 2'b00;
            r_stable_d <= 2'b00;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= w_stable;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic [c_dcw-1:0] r_cnt;
            logic             r_level;

            // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (r_sync2[gi] == r_level) begin
                    r_cnt   <= '0;
                end else if (r_cnt == c_deb_last) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            assign w_stable[gi] = r_level;
        end
    endgenerate

    assign w_press      = w_stable & ~r_stable_d;
    assign w_frame_edge = (r_frame == c_frame_last);

    // 33-bit difference so extreme obstacle positions cannot wrap into the window
    assign w_dx  = $signed({ev.obstacle_x[31], ev.obstacle_x}) - c_dino_x;
    assign w_hit = (w_dx > -c_hit_w) && (w_dx < c_hit_w) &&
                   ($signed(ev.dino_y) < c_hit_h);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame <= '0;
            r_screen <= 1'b0;
        end else begin
            r_frame  <= w_frame_edge ? '0 : r_frame + 1'b1;
            r_screen <= w_frame_edge;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_button       <= 1'b0;
            r_collision    <= 1'b0;
            r_pause        <= 1'b0;
            r_jump_pending <= 1'b0;
        end else begin
            if (w_press[1])
                r_pause <= ~r_pause;

            if (w_frame_edge && !r_pause) begin
                r_button <= r_jump_pending;
                // A pending jump restarts after a crash and masks this frame's hit
                if (r_collision && r_jump_pending)
                    r_collision <= 1'b0;
                else if (w_hit)
                    r_collision <= 1'b1;
                r_jump_pending <= w_press[0];
            end else begin
                if (w_frame_edge)
                    r_button <= 1'b0;
                if (w_press[0])
                    r_jump_pending <= 1'b1;
            end
        end
    end

    assign ev.button_signal    = r_button;
    assign ev.screen_signal    = r_screen;
    assign ev.collision_signal = r_collision;
    assign ev.pause_signal     = r_pause;

endmodule
`default_nettype wire

// File: doc/game_event_gen.md
# game_event_gen

Front-end event generator feeding the dinosaur-game processor wrapper. It synchronises and debounces the raw jump and pause buttons and generates the per-frame screen tick. It checks dino/obstacle overlap once per frame from the register-file position outputs (r16 = dino height, r17 = obstacle x). It drives the wrapper's `button_signal`, `screen_signal`, `collision_signal` and `pause_signal` inputs, so software can poll clean, frame-aligned flags.

## Interface
- `DEBOUNCE_CYCLES`, 500000: cycles a synced button level must hold before the debounced level changes.
- `FRAME_CYCLES`, 833333: frame period in clocks (60 Hz at 50 MHz).
- `DINO_X`, 64: fixed dino x position (signed 32-bit).
- `HIT_W`, 24: horizontal hit half-window.
- `HIT_H`, 32: dino height below which an overlap is a hit.
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `btn_jump_raw`  in  1  raw jump pushbutton, asynchronous, active-high.
- `btn_pause_raw`  in  1  raw pause pushbutton, asynchronous, active-high.
- `dino_y`  in  32  dino height above ground, signed (from r16).
- `obstacle_x`  in  32  obstacle x position, signed (from r17).
- `button_signal`  out  1  jump event, held for one full frame.
- `screen_signal`  out  1  one-cycle frame-tick pulse.
- `collision_signal`  out  1  sticky collision flag.
- `pause_signal`  out  1  pause state, toggled by each pause press.

## Operation
- **Reset.** While `reset`=0, every output, counter, sync flop, debounced level and `jump_pending` is 0. Release is synchronous to the next `clock` edge.
- **Synchroniser.** Each raw button passes through a 2-flop synchroniser.
- **Debouncer, one per button.**
  - Keeps a stable level and a counter.
  - Counter clears whenever the synced input equals the stable level; otherwise it increments.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the input still differs, the stable level flips and the counter clears.
  - A bounce shorter than `DEBOUNCE_CYCLES` cycles is never seen.
- **Edge detect.** A rising edge of a stable level yields a one-cycle internal press strobe.
- **Frame counter.**
  - Counts 0..`FRAME_CYCLES-1` and wraps to 0.
  - The edge on which it wraps is the *frame edge*. It runs regardless of pause.
- **Jump path.**
  - A jump strobe sets `jump_pending`.
  - At a frame edge with `pause_signal`=0: `button_signal` <= `jump_pending`, then `jump_pending` clears.
  - If a strobe arrives on that same edge, `jump_pending` stays set, so the press is delivered next frame.
  - Multiple presses within one frame coalesce into one event.
  - At a frame edge while paused: `button_signal` <= 0 and `jump_pending` is preserved.
- **Pause.** A pause strobe toggles `pause_signal` on the following edge. No frame alignment.
- **Collision, evaluated only at frame edges with `pause_signal`=0.**
  - Compute `d = obstacle_x - DINO_X` as 33-bit signed.
  - Hit = (`d` > -`HIT_W`) and (`d` < `HIT_W`) and (signed `dino_y` < `HIT_H`).
  - A hit sets `collision_signal`; it stays set (sticky).
  - Restart: at a frame edge where `collision_signal`=1 and `jump_pending`=1, `collision_signal` <= 0 and `button_signal` <= 1. No hit is evaluated on that edge (clear has priority over set).
  - While paused, `collision_signal` holds.
- **Position inputs.** `dino_y` and `obstacle_x` are sampled only at frame edges and may change at any other time.

## Timing
- `screen_signal` is high for exactly the one cycle after each frame edge, i.e. while the frame counter = 0. The period is `FRAME_CYCLES` cycles.
- The first `screen_signal` after reset release follows `FRAME_CYCLES` edges.
- `button_signal` and `collision_signal` change only on frame edges, coincident with the `screen_signal` rise.
- `button_signal` stays stable for a whole frame.
- Press-to-debounced latency: 2 (sync) + `DEBOUNCE_CYCLES` cycles after a clean raw edge.
- `pause_signal` latency from a clean raw edge: 2 + `DEBOUNCE_CYCLES` + 1 cycles.
- Jump delivery: at the first frame edge at or after `jump_pending` sets.
- Reset asserted mid-frame or mid-debounce: all state clears immediately, with no partial event afterward.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `FRAME_CYCLES`=20, `DINO_X`=64, `HIT_W`=24, `HIT_H`=32.
- **Reset then idle.** Hold `reset`=0 for 5 cycles, release -> all outputs 0. `screen_signal` pulses 1 cycle every 20 cycles; `button_signal`, `collision_signal` and `pause_signal` stay 0.
- **Bounce rejection.** Jump raw toggles high/low every 2 cycles for 20 cycles, then stays low -> no press, `button_signal` stays 0. A clean 10-cycle high -> `button_signal`=1 for exactly one 20-cycle frame, then 0.
- **Coalescing and same-edge press.** Two clean presses in one frame -> one single-frame `button_signal` assertion. A press whose strobe lands on a frame edge -> delivered at the next frame edge.
- **Collision window.** `dino_y`=0 with `obstacle_x`=41 -> hit at the next frame edge; `obstacle_x`=40 or 88 -> no hit; `obstacle_x`=87 -> hit. `dino_y`=32 with `obstacle_x`=64 -> no hit. Once set, `collision_signal` stays 1 after `obstacle_x` moves to 500.
- **Restart.** With `collision_signal`=1, a jump press -> at the next frame edge `collision_signal`=0 and `button_signal`=1 in the same cycle, even with a hit still present on the inputs.
- **Pause.** A pause press toggles `pause_signal` to 1. A jump during pause gives `button_signal` 0 and no collision update while `screen_signal` keeps pulsing. A second pause press returns it to 0, and the held jump is delivered at the next frame edge.
